// File: rtl/pid_bus_arbiter_pkg.sv
// Shared definitions for the particle-ID local-bus arbiter: widths, requester
// indices, sequencer state encoding and the latched command record.
package pid_bus_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_SCAN = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WSTB = 2'd1;
    localparam logic [1:0] ST_RSTB = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/pid_bus_arbiter_rr_grant2.sv
// Two-way round-robin grant with a scan-engine lock override; remembers which
// requester completed most recently.
module pid_bus_arbiter_rr_grant2
    import pid_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid_i,
    input  logic       lock_i,
    input  logic       update_i,
    input  logic       owner_i,
    output logic [1:0] grant_o
);

    logic last_owner_q;
    logic last_owner_d;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                if (lock_i && (last_owner_q == REQ_SCAN)) begin
                    grant_o = 2'b10;
                end else begin
                    grant_o = (last_owner_q == REQ_SCAN) ? 2'b01 : 2'b10;
                end
            end
            default: grant_o = 2'b00;
        endcase
    end

    assign last_owner_d = update_i ? owner_i : last_owner_q;

    // Resetting to the scan engine makes the first conflict go to the host.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
        if (rst) begin
            last_owner_q <= REQ_SCAN;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/pid_bus_arbiter.sv
// Arbiter/sequencer turning host and scan-engine commands into single Write
// strobes and RD_LAT-cycle Read strobes on the particle-ID local bus.
module pid_bus_arbiter
    import pid_bus_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_wr,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    input  logic                   b_lock,
    output logic [1:0]             resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   busy,
    output logic [ADDR_W-1:0]      Address,
    output logic [DATA_W-1:0]      DataIn,
    output logic                   Read,
    output logic                   Write,
    input  logic [DATA_W-1:0]      DataOut
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("pid_bus_arbiter: RD_LAT must be in 1..4");
    end

    logic [1:0]        state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              owner_q, owner_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        grant;
    logic              gidx;
    logic              accept;

    pid_bus_arbiter_rr_grant2 u_rr_grant2 (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .lock_i      (b_lock),
        .update_i    (state_q == ST_RESP),
        .owner_i     (owner_q),
        .grant_o     (grant)
    );

    assign gidx   = grant[1];
    assign accept = (state_q == ST_IDLE) && (grant != 2'b00) && !rst;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = gidx;
                    cmd_d   = '{wr: req_wr[gidx], addr: req_addr[gidx], wdata: req_wdata[gidx]};
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = req_wr[gidx] ? ST_WSTB : ST_RSTB;
                end
            end
            ST_WSTB: state_d = ST_RESP;
            ST_RSTB: begin
                // The counter reaching zero marks the last Read cycle.
                if (cnt_q == 2'd0) begin
                    rdata_d = DataOut;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            owner_q <= REQ_HOST;
            cnt_q   <= 2'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready  = accept ? grant : 2'b00;
    assign busy       = (state_q != ST_IDLE);
    assign Read       = (state_q == ST_RSTB);
    assign Write      = (state_q == ST_WSTB);
    assign Address    = cmd_q.addr;
    assign DataIn     = cmd_q.wdata;
    assign resp_valid = (state_q != ST_RESP) ? 2'b00 :
                        (owner_q == REQ_SCAN) ? 2'b10 : 2'b01;
    assign resp_rdata = (state_q == ST_RESP && !cmd_q.wr) ? rdata_q : '0;

endmodule

// File: tb/tb_pid_bus_arbiter.sv
// Randomised bench for pid_bus_arbiter: a transaction-level timeline model plus
// a register-bank slave predicts grants, strobes and read data.
module tb_pid_bus_arbiter;

    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid, req_ready, req_wr, resp_valid;
    logic [1:0][7:0]   req_addr;
    logic [1:0][31:0]  req_wdata;
    logic              b_lock;
    logic [31:0]       resp_rdata, DataIn, DataOut;
    logic              busy, Read, Write;
    logic [7:0]        Address;

    int n_cmp = 0;
    int n_err = 0;
    int model_last;                  // 0 = host served last, 1 = scan engine
    logic [31:0] mem [256];          // slave register banks driven by the DUT bus
    logic [31:0] model_mem [256];    // contents the bench expects

    always #5 clk = ~clk;

    pid_bus_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .b_lock     (b_lock),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .Address    (Address),
        .DataIn     (DataIn),
        .Read       (Read),
        .Write      (Write),
        .DataOut    (DataOut)
    );

    assign DataOut = Read ? mem[Address] : 32'h0;
    always @(posedge clk) if (Write) mem[Address] <= DataIn;

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if ((Read && Write) || (!busy && (Read || Write))) begin
                n_err++;
                $display("FAIL strobe_rules: Read=%b Write=%b busy=%b, required never both and none while idle",
                         Read, Write, busy);
            end
        end
    end

    function automatic int predict_owner(input logic [1:0] v, input logic lock, input int last);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (lock && last == 1) return 1;
        return 1 - last;
    endfunction

    task automatic scramble_inputs();
        req_valid = 2'($urandom);
        req_wr    = 2'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = {$urandom, $urandom};
        b_lock    = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0; b_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1;
    endtask

    // Offer one arbitration slot from an IDLE cycle and follow the predicted timeline.
    task automatic run_slot(input logic [1:0] v, input logic [1:0] wr, input logic [1:0][7:0] addr,
                            input logic [1:0][31:0] wd, input logic lock);
        int owner, lat;
        logic [1:0] exp_ready, exp_rv;
        logic [31:0] exp_rd;
        req_valid = v; req_wr = wr; req_addr = addr; req_wdata = wd; b_lock = lock;
        owner = predict_owner(v, lock, model_last);
        exp_ready = (owner < 0) ? 2'b00 : 2'(1 << owner);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, busy, Read, Write, resp_valid} !== {exp_ready, 5'b0}) begin
            n_err++;
            $display("FAIL accept: ready/busy/rd/wr/resp got %b %b %b %b %b, required %b 0 0 0 00",
                     req_ready, busy, Read, Write, resp_valid, exp_ready);
        end
        @(posedge clk); #1;
        if (owner < 0) return;
        lat = wr[owner] ? 1 : RD_LAT;
        if (wr[owner]) model_mem[addr[owner]] = wd[owner];
        exp_rd = wr[owner] ? 32'h0 : model_mem[addr[owner]];
        scramble_inputs();
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({Read, Write, busy, req_ready, resp_valid, Address, DataIn} !==
                {!wr[owner], wr[owner], 1'b1, 2'b00, 2'b00, addr[owner], wd[owner]}) begin
                n_err++;
                $display("FAIL strobe_cycle%0d: rd=%b wr=%b busy=%b ready=%b resp=%b addr=%h din=%h, required rd=%b wr=%b busy=1 ready=00 resp=00 addr=%h din=%h",
                         k, Read, Write, busy, req_ready, resp_valid, Address, DataIn,
                         !wr[owner], wr[owner], addr[owner], wd[owner]);
            end
            @(posedge clk); #1;
            scramble_inputs();
        end
        exp_rv = 2'(1 << owner);
        @(negedge clk);
        n_cmp++;
        if ({resp_valid, resp_rdata, busy, Read, Write, req_ready, Address, DataIn} !==
            {exp_rv, exp_rd, 1'b1, 1'b0, 1'b0, 2'b00, addr[owner], wd[owner]}) begin
            n_err++;
            $display("FAIL resp: resp=%b rdata=%h busy=%b rd=%b wr=%b ready=%b addr=%h, required resp=%b rdata=%h busy=1 rd=0 wr=0 ready=00 addr=%h",
                     resp_valid, resp_rdata, busy, Read, Write, req_ready, Address,
                     exp_rv, exp_rd, addr[owner]);
        end
        model_last = owner;
        @(posedge clk); #1;
    endtask

    task automatic rand_slot(input logic [1:0] v, input logic lock);
        logic [1:0][7:0]  a;
        logic [1:0][31:0] d;
        a[0] = 8'($urandom_range(0, 15));
        a[1] = 8'($urandom_range(0, 15));
        d = {$urandom, $urandom};
        run_slot(v, 2'($urandom), a, d, lock);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0; b_lock = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({Read, Write, Address, DataIn, resp_valid, resp_rdata, busy} !== 77'h0) begin
            n_err++;
            $display("FAIL reset_values: rd=%b wr=%b addr=%h din=%h resp=%b rdata=%h busy=%b, required all zero",
                     Read, Write, Address, DataIn, resp_valid, resp_rdata, busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        model_last = 1;
    endtask

    task automatic test_host_write();
        run_slot(2'b01, 2'b01, {8'h00, 8'h04}, {32'h0, 32'h0000F0F0}, 1'b0);
    endtask

    task automatic test_scan_read();
        mem[8'h0A] = 32'h0F000000;
        model_mem[8'h0A] = 32'h0F000000;
        run_slot(2'b10, 2'b00, {8'h0A, 8'h00}, {32'h0, 32'h0}, 1'b0);
    endtask

    task automatic test_alternate();
        do_reset();
        repeat (4) rand_slot(2'b11, 1'b0);
    endtask

    task automatic test_lock();
        repeat (3) rand_slot(2'b11, 1'b1);
        rand_slot(2'b11, 1'b0);
        rand_slot(2'b01, 1'b1);
    endtask

    task automatic test_reset_abort();
        do_reset();
        mem[8'h33] = 32'hA5A5_0033;
        model_mem[8'h33] = 32'hA5A5_0033;
        req_valid = 2'b10; req_wr = 2'b00; req_addr[1] = 8'h33;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL abort_accept: ready=%b, required 10", req_ready);
        end
        @(posedge clk); #1 req_valid = 2'b00;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (Read !== 1'b1) begin
            n_err++;
            $display("FAIL abort_cycle2_read: Read=%b, required 1", Read);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({Read, Write, busy, resp_valid} !== 5'b0) begin
                n_err++;
                $display("FAIL abort_idle%0d: rd=%b wr=%b busy=%b resp=%b, required all zero",
                         k, Read, Write, busy, resp_valid);
            end
            @(posedge clk); #1;
        end
        model_last = 1;
        run_slot(2'b01, 2'b00, {8'h00, 8'h33}, {32'h0, 32'h0}, 1'b0);
        rand_slot(2'b11, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom;
        run_slot(2'b01, 2'b01, {8'h00, 8'h08}, {32'h0, d}, 1'b0);
        run_slot(2'b01, 2'b00, {8'h00, 8'h08}, {32'h0, 32'h0}, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) rand_slot(2'($urandom), 1'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            model_mem[i] = 32'h0;
        end
        test_reset();
        test_host_write();
        test_scan_read();
        test_alternate();
        test_lock();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pid_bus_arbiter.md
# pid_bus_arbiter

Two-requester arbiter and sequencer for the 8-bit-address local bus feeding the particle-ID channel register banks (per-channel config, electron, pion and muon window registers, logic-analyzer readout). It sits between the slow-control host port (requester 0) and the automatic window-scan engine (requester 1). It serialises their single-word read and write commands into one-cycle Write strobes and multi-cycle Read strobes on the shared bus, and returns read data sampled from the OR-combined slave `DataOut`.

## Interface
Parameters:
- `RD_LAT`, 1, cycles `Read` is held before `DataOut` is sampled; legal 1..4.

Ports:
- `clk`  in  1  bus clock, the 50 MHz `clk[2]` domain; single clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  2  per-requester command valid; bit 0 host, bit 1 scan engine.
- `req_ready`  out  2  one-hot accept; the command is taken on a cycle with valid & ready.
- `req_wr`  in  2  per-requester 1 = write, 0 = read.
- `req_addr`  in  2x8  per-requester local-bus address.
- `req_wdata`  in  2x32  per-requester write data.
- `b_lock`  in  1  scan engine holds the bus across consecutive commands (read-modify-write).
- `resp_valid`  out  2  one-cycle completion pulse to the owning requester.
- `resp_rdata`  out  32  read data; valid with `resp_valid`; 0 for writes.
- `busy`  out  1  a transaction is in flight.
- `Address`  out  8  bus address.
- `DataIn`  out  32  bus write data (slave-side name).
- `Read`  out  1  bus read strobe.
- `Write`  out  1  bus write strobe.
- `DataOut`  in  32  OR of all slave read buses.

## Operation
- States: IDLE, WSTB, RSTB, RESP.
- IDLE: compute grant from `req_valid`, assert the matching `req_ready` combinationally, and latch wr/addr/wdata and owner. Go to WSTB on a write, RSTB on a read.
- Arbitration when both requesters are valid:
  - Default is round-robin on `last_owner`; the requester not served last wins.
  - If `b_lock`=1 and `last_owner`=1, requester 1 wins regardless.
  - `b_lock` has no effect when `req_valid[1]`=0, so the host is served.
- A single valid requester is always granted, with no idle bubble.
- WSTB: `Write`=1 for exactly one cycle, then RESP.
- RSTB: `Read`=1 for `RD_LAT` consecutive cycles. `DataOut` is registered at the clock edge ending the last `Read` cycle, then RESP.
- RESP: `resp_valid[owner]`=1 for one cycle and `last_owner`<=owner. The state returns to IDLE on the same edge, so arbitration runs in the cycle after RESP.
- There is no response backpressure; requesters must accept `resp_valid` at any time.
- Only one command is outstanding. `req_ready` is 0 in every state except IDLE.
- `Address`/`DataIn` are driven from the latched command from the WSTB/RSTB cycle through RESP. Otherwise they hold their last value.

## Timing
- Reset values:
  - state IDLE, `last_owner`=1 (so the first conflict goes to the host).
  - `Read`=`Write`=0, `Address`=0, `DataIn`=0.
  - `resp_valid`=0, `resp_rdata`=0, `busy`=0.
- Write: accept at cycle 0, `Write` at cycle 1, `resp_valid` at cycle 2, next accept at cycle 3. Throughput is 1 write per 3 cycles.
- Read: accept at cycle 0, `Read` at cycles 1..`RD_LAT`, `resp_valid`+data at cycle `RD_LAT`+1.
- `busy`=1 from the cycle after accept through RESP inclusive.
- `Read` and `Write` are never high together and never high in IDLE.
- Requester inputs are ignored except in the accept cycle; later changes do not alter the bus.
- `rst` mid-transaction: the next edge forces IDLE and drops the strobes. No `resp_valid` is issued for the aborted command, and `last_owner`=1.
- Illegal `RD_LAT` (0 or >4): not supported; elaboration-time check only.

## Structure
- Shared package: state encoding, `REQ_HOST`=0, `REQ_SCAN`=1, bus widths (ADDR_W=8, DATA_W=32).
- One natural sub-module, `rr_grant2`: a 2-way round-robin grant with lock override, purely combinational plus the `last_owner` flop.
- Read-latency counter is 2 bits, local to the top.
- Expected RTL size is about 150–200 lines.

## Test plan
- Host write addr 0x04 data 0x0000F0F0 alone -> `Write` high only cycle 1 with `Address`=0x04, `DataIn`=0x0000F0F0; `resp_valid`=2'b01 cycle 2; `resp_rdata`=0.
- Scan read addr 0x0A, `RD_LAT`=3, `DataOut`=0x0F000000 on cycles 1..3 -> `Read` high cycles 1–3; `resp_valid`=2'b10 cycle 4, `resp_rdata`=0x0F000000.
- Both requesters valid continuously after reset -> grants alternate host, scan, host, scan; each accepted one cycle after the prior RESP.
- Scan holds `b_lock`=1 for 3 commands while host is valid -> 3 scan transactions back-to-back, then host is granted on the first IDLE after `b_lock` drops.
- Assert `rst` during cycle 2 of an `RD_LAT`=3 read -> `Read`=0 on the next cycle; no `resp_valid`; a subsequent host read completes normally.
- Host write then immediate read of the same address (0x08) -> read returns the written value from the Register model; `Read`/`Write` are never simultaneous.
